video_sequencer: RTL and testbench
==================================

VIDEO_SEQUENCER -- requirements
Module: video_sequencer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- HDISP 800: active pixels per line.
- VDISP 480: active lines per frame.
- HFP 40, HPULSE 48, HBP 40: horizontal front porch, sync pulse and back porch, in pixels.
- VFP 13, VPULSE 3, VBP 29: vertical front porch, sync pulse and back porch, in lines.
REQ-002 Ports (name, direction, width, meaning), one per line:
- pixel_clk, in, 1: clock.
- pixel_rst, in, 1: reset, asynchronous, active-high.
- enable, in, 1: request video output.
- fifo_wfull, in, 1: FIFO full flag; asynchronous, from the write-clock domain.
- fifo_rempty, in, 1: FIFO empty flag; pixel_clk domain.
- fifo_rdata, in, 24: show-ahead FIFO data, RGB.
- fifo_read, out, 1: FIFO pop.
- hs, out, 1: horizontal sync, active-low.
- vs, out, 1: vertical sync, active-low.
- blank, out, 1: display-active strobe; high means a visible pixel.
- rgb, out, 24: pixel data.
- frame_start, out, 1: one-cycle pulse at the start of each frame.
- busy, out, 1: high whenever state is not IDLE.
- underflow_cnt, out, 8: saturating count of FIFO underflow events.

Function
REQ-003 Derived constants: HSUM=HFP+HPULSE+HBP; VSUM=VFP+VPULSE+VBP; HTOT=HSUM+HDISP; VTOT=VSUM+VDISP.
REQ-004 fifo_wfull SHALL pass through a 2-flop synchronizer before use; the synchronized signal is wfull_s.
REQ-005 FSM states:
- IDLE -> WAIT_FILL when enable=1.
- WAIT_FILL -> RUN on the first cycle with wfull_s=1.
- WAIT_FILL -> IDLE when enable=0.
- RUN -> IDLE only at frame wrap (p=HTOT-1, l=VTOT-1) with enable=0; the current frame always completes.
REQ-006 Counters p in 0..HTOT-1 and l in 0..VTOT-1 SHALL advance only in RUN.
- p wraps to 0 and increments l at p=HTOT-1.
- l wraps to 0 at VTOT-1.
- Both counters are cleared on entry to RUN.
- Counter widths are $clog2(HTOT) and $clog2(VTOT).
REQ-007 act = (state==RUN) && p>=HSUM && l>=VSUM; fifo_read = act, combinational.
REQ-008 Outputs SHALL be registered with one-cycle latency from the counter values:
- hs = !(RUN && HFP<=p<HFP+HPULSE).
- vs = !(RUN && VFP<=l<VFP+VPULSE).
- blank = act.
REQ-009 rgb register:
- fifo_rdata when act && !fifo_rempty.
- 24'h0 otherwise.
- rgb is therefore aligned with blank.
REQ-010 Underflow: act && fifo_rempty SHALL increment underflow_cnt, saturating at 255.
- fifo_read is still asserted during an underflow.
- Timing continues unchanged; there is no resync.
REQ-011 frame_start SHALL be registered high for exactly one cycle following each cycle where RUN && p==0 && l==0.
REQ-012 Exactly HDISP*VDISP fifo_read pulses SHALL occur per completed frame.
REQ-013 Outside RUN: fifo_read=0, hs=1, vs=1, blank=0, rgb=0, frame_start=0.
REQ-014 A mid-frame drop of enable SHALL affect nothing until frame wrap.
REQ-015 Re-asserting enable at the wrap cycle SHALL still enter IDLE, then WAIT_FILL on the next cycle.

Reset
REQ-016 On pixel_rst the block SHALL enter this state asynchronously:
- State IDLE; p=0, l=0.
- Synchronizer flops 0; underflow_cnt=0.
- hs=1, vs=1, blank=0, rgb=0, frame_start=0, busy=0.
REQ-017 Reset asserted mid-frame SHALL abort immediately; after release the block restarts via WAIT_FILL.

Structure
REQ-018 A shared package video_pkg SHALL hold:
- The FSM state enum (IDLE, WAIT_FILL, RUN).
- Default timing constants.
- HSUM, VSUM, HTOT and VTOT helper functions.
REQ-019 The synchronizer SHALL be a separate sub-module, sync2, with width parameter 1; all other logic stays in video_sequencer.

Verification
REQ-020 Benches SHALL use HDISP=4, VDISP=2, HFP=HPULSE=HBP=VFP=VPULSE=VBP=1, giving HTOT=7, VTOT=5 and 35 cycles per frame.
REQ-021 Scenarios:
- Fill start: enable=1 with wfull toggled high at cycle 10 -> RUN entered no earlier than 2 cycles later; first frame_start follows; 8 fifo_read and 8 blank cycles per frame; hs low 1 cycle per line at p=1; vs low for 7 cycles at l=1.
- Data path: FIFO model supplies 0x000001..0x000008 -> rgb sequence 1..8, each coincident with blank=1.
- Underflow: fifo_rempty=1 during 3 active cycles -> underflow_cnt=3 and rgb=0 on those cycles; hs/vs period still 7/35 cycles.
- Saturation: permanent empty over 40 frames (320 events) -> underflow_cnt stays 255.
- Graceful stop: enable drops at cycle 5 of a frame -> frame completes (all 8 reads), then busy=0, hs=vs=1.
- Async reset mid-frame -> all outputs at reset values within the same cycle; after release with wfull=1, RUN is re-entered via WAIT_FILL.

Source files
------------

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared types, default timing and timing helpers for the video sequencer
// Contents:
//   state_t        sequencer FSM state
//   DEF_*          default panel timing (800x480)
//   RGB_W          pixel data width
//   hsum/vsum      blanking lengths (porch + pulse + porch)
//   htot/vtot      total line length / frame height
package video_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_FILL = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int RGB_W      = 24;

    localparam int DEF_HDISP  = 800;
    localparam int DEF_VDISP  = 480;
    localparam int DEF_HFP    = 40;
    localparam int DEF_HPULSE = 48;
    localparam int DEF_HBP    = 40;
    localparam int DEF_VFP    = 13;
    localparam int DEF_VPULSE = 3;
    localparam int DEF_VBP    = 29;

    function automatic int hsum(input int hfp, input int hpulse, input int hbp);
        return hfp + hpulse + hbp;
    endfunction

    function automatic int vsum(input int vfp, input int vpulse, input int vbp);
        return vfp + vpulse + vbp;
    endfunction

    function automatic int htot(input int hdisp, input int hfp, input int hpulse, input int hbp);
        return hsum(hfp, hpulse, hbp) + hdisp;
    endfunction

    function automatic int vtot(input int vdisp, input int vfp, input int vpulse, input int vbp);
        return vsum(vfp, vpulse, vbp) + vdisp;
    endfunction

endpackage

// File: rtl/video_if.sv
// rtl/video_if.sv - pixel FIFO read-side bundle between FIFO and video sequencer
// Signals:
//   fifo_wfull   FIFO full flag, write-clock domain (asynchronous to the reader)
//   fifo_rempty  FIFO empty flag, pixel_clk domain
//   fifo_rdata   show-ahead head-of-FIFO RGB data
//   fifo_read    pop strobe from the sequencer
// Modports: master = FIFO side, slave = sequencer side.
interface video_if;
    import video_pkg::*;

    logic             fifo_wfull;
    logic             fifo_rempty;
    logic [RGB_W-1:0] fifo_rdata;
    logic             fifo_read;

    modport master (
        output fifo_wfull,
        output fifo_rempty,
        output fifo_rdata,
        input  fifo_read
    );

    modport slave (
        input  fifo_wfull,
        input  fifo_rempty,
        input  fifo_rdata,
        output fifo_read
    );

endinterface

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for signals entering the local clock domain
// Ports:
//   clk  destination clock
//   rst  asynchronous active-high reset, clears both stages
//   d    asynchronous input
//   q    synchronized output (two clk cycles of latency)
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/video_sequencer.sv
// rtl/video_sequencer.sv - raster timing generator that streams pixels from a show-ahead FIFO
// Ports:
//   pixel_clk, pixel_rst  pixel clock, asynchronous active-high reset
//   enable                request video; dropping it stops at the next frame wrap
//   fifo                  video_if.slave: wfull/rempty/rdata in, fifo_read out
//   hs, vs                active-low syncs (registered)
//   blank                 high on visible pixels (registered, aligned with rgb)
//   rgb                   pixel data, zero outside active area or on underflow
//   frame_start           one-cycle pulse at the start of each frame
//   busy                  sequencer not idle
//   underflow_cnt         saturating count of reads attempted on an empty FIFO
// A raster line is laid out as front porch, sync, back porch, then active pixels,
// so p/l counters start in blanking and the active window is the tail of each.
module video_sequencer
    import video_pkg::*;
#(
    parameter int HDISP  = DEF_HDISP,
    parameter int VDISP  = DEF_VDISP,
    parameter int HFP    = DEF_HFP,
    parameter int HPULSE = DEF_HPULSE,
    parameter int HBP    = DEF_HBP,
    parameter int VFP    = DEF_VFP,
    parameter int VPULSE = DEF_VPULSE,
    parameter int VBP    = DEF_VBP
) (
    input  logic             pixel_clk,
    input  logic             pixel_rst,
    input  logic             enable,
    video_if.slave           fifo,
    output logic             hs,
    output logic             vs,
    output logic             blank,
    output logic [RGB_W-1:0] rgb,
    output logic             frame_start,
    output logic             busy,
    output logic [7:0]       underflow_cnt
);

    localparam int HSUM = hsum(HFP, HPULSE, HBP);
    localparam int VSUM = vsum(VFP, VPULSE, VBP);
    localparam int HTOT = htot(HDISP, HFP, HPULSE, HBP);
    localparam int VTOT = vtot(VDISP, VFP, VPULSE, VBP);
    localparam int PW   = $clog2(HTOT);
    localparam int LW   = $clog2(VTOT);

    localparam logic [PW-1:0] P_LAST  = PW'(HTOT - 1);
    localparam logic [PW-1:0] P_ACT   = PW'(HSUM);
    localparam logic [PW-1:0] P_HS_LO = PW'(HFP);
    localparam logic [PW-1:0] P_HS_HI = PW'(HFP + HPULSE);
    localparam logic [LW-1:0] L_LAST  = LW'(VTOT - 1);
    localparam logic [LW-1:0] L_ACT   = LW'(VSUM);
    localparam logic [LW-1:0] L_VS_LO = LW'(VFP);
    localparam logic [LW-1:0] L_VS_HI = LW'(VFP + VPULSE);

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] p;
    logic [LW-1:0] l;
    logic          wfull_s;
    logic          run;
    logic          act;
    logic          p_wrap;
    logic          frame_wrap;

    sync2 #(.WIDTH(1)) u_wfull_sync (
        .clk (pixel_clk),
        .rst (pixel_rst),
        .d   (fifo.fifo_wfull),
        .q   (wfull_s)
    );

    assign p_wrap     = (p == P_LAST);
    assign frame_wrap = p_wrap && (l == L_LAST);

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Dropping enable while waiting for the fill abandons the start; once
    // running, only the frame wrap may return to IDLE so frames are never torn.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (enable) state_nxt = WAIT_FILL;
            WAIT_FILL: begin
                if (!enable)      state_nxt = IDLE;
                else if (wfull_s) state_nxt = RUN;
            end
            RUN:       if (frame_wrap && !enable) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        run            = (state == RUN);
        act            = run && (p >= P_ACT) && (l >= L_ACT);
        busy           = (state != IDLE);
        fifo.fifo_read = act;
    end

    // Counters sit at zero outside RUN, which gives the clear-on-entry for free.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            p <= '0;
            l <= '0;
        end else if (!run) begin
            p <= '0;
            l <= '0;
        end else if (p_wrap) begin
            p <= '0;
            l <= frame_wrap ? '0 : l + 1'b1;
        end else begin
            p <= p + 1'b1;
        end
    end

    // Registered outputs carry one cycle of latency so rgb lines up with blank;
    // underflows still pop and keep timing, the pixel is just forced to black.
    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs            <= 1'b1;
            vs            <= 1'b1;
            blank         <= 1'b0;
            rgb           <= '0;
            frame_start   <= 1'b0;
            underflow_cnt <= '0;
        end else begin
            hs          <= !(run && (p >= P_HS_LO) && (p < P_HS_HI));
            vs          <= !(run && (l >= L_VS_LO) && (l < L_VS_HI));
            blank       <= act;
            rgb         <= (act && !fifo.fifo_rempty) ? fifo.fifo_rdata : '0;
            frame_start <= run && (p == '0) && (l == '0);
            if (act && fifo.fifo_rempty && (underflow_cnt != 8'hFF)) begin
                underflow_cnt <= underflow_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_sequencer.sv
// tb/tb_video_sequencer.sv - directed self-checking bench for video_sequencer
module tb_video_sequencer;
    import video_pkg::*;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst = 1'b1;
    logic        enable = 1'b0;
    logic        wfull = 1'b0;
    logic        force_empty = 1'b0;
    logic        hs, vs, blank, frame_start, busy;
    logic [23:0] rgb;
    logic [7:0]  underflow_cnt;
    int unsigned rd_idx = 0;
    int          checks = 0;
    int          errors = 0;

    video_if fif();

    assign fif.fifo_wfull  = wfull;
    assign fif.fifo_rempty = force_empty;
    assign fif.fifo_rdata  = 24'(rd_idx + 1);

    always #5 pixel_clk = ~pixel_clk;

    // Show-ahead FIFO model: head value is rd_idx+1, popped on read when not empty.
    always @(posedge pixel_clk) begin
        if (fif.fifo_read && !fif.fifo_rempty) rd_idx <= rd_idx + 1;
    end

    video_sequencer #(
        .HDISP(4), .VDISP(2),
        .HFP(1), .HPULSE(1), .HBP(1),
        .VFP(1), .VPULSE(1), .VBP(1)
    ) dut (
        .pixel_clk     (pixel_clk),
        .pixel_rst     (pixel_rst),
        .enable        (enable),
        .fifo          (fif),
        .hs            (hs),
        .vs            (vs),
        .blank         (blank),
        .rgb           (rgb),
        .frame_start   (frame_start),
        .busy          (busy),
        .underflow_cnt (underflow_cnt)
    );

    typedef struct {
        int          t;
        logic        hs;
        logic        vs;
        logic        blank;
        logic        rd;
        logic        fs;
        logic [23:0] rgb;
    } vec_t;

    localparam int NV = 15;
    vec_t tbl [NV];

    task automatic tick();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hs"}, hs, 1);
        check({tag, "_vs"}, vs, 1);
        check({tag, "_blank"}, blank, 0);
        check({tag, "_rgb"}, rgb, 0);
        check({tag, "_fs"}, frame_start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ucnt"}, underflow_cnt, 0);
        check({tag, "_rd"}, fif.fifo_read, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit found;
        int c_hs, c_vs, c_bl, c_rd, nz;

        // t = samples after the first frame_start sample; registered outputs at
        // sample t reflect frame cycle k=t, fifo_read reflects k=t+1.
        tbl[0]  = '{0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'd0};
        tbl[1]  = '{1,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0};
        tbl[2]  = '{2,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0};
        tbl[3]  = '{7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0};
        tbl[4]  = '{8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0};
        tbl[5]  = '{13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0};
        tbl[6]  = '{14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0};
        tbl[7]  = '{23, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'd0};
        tbl[8]  = '{24, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'd1};
        tbl[9]  = '{27, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'd4};
        tbl[10] = '{28, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'd0};
        tbl[11] = '{30, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 24'd0};
        tbl[12] = '{31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 24'd5};
        tbl[13] = '{34, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 24'd8};
        tbl[14] = '{35, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 24'd0};

        // Reset state
        tick();
        tick();
        check_reset_values("reset");

        // Fill start: wait in WAIT_FILL, then wfull rises at cycle 10
        pixel_rst = 1'b0;
        enable    = 1'b1;
        repeat (10) tick();
        check("wait_busy", busy, 1);
        check("wait_fs", frame_start, 0);
        check("wait_rd", fif.fifo_read, 0);
        check("wait_hs", hs, 1);
        wfull = 1'b1;
        n = 0;
        found = 0;
        while (!found && n < 10) begin
            tick();
            n++;
            if (frame_start) found = 1;
        end
        check("fill_latency", n, 4);

        // Frame 1: table-driven timing and data path
        c_hs = 0; c_vs = 0; c_bl = 0; c_rd = 0;
        for (int t = 0; t <= 35; t++) begin
            if (t > 0) tick();
            if (t <= 34) begin
                if (!hs) c_hs++;
                if (!vs) c_vs++;
                if (blank) c_bl++;
                if (fif.fifo_read) c_rd++;
            end
            for (int i = 0; i < NV; i++) begin
                if (tbl[i].t == t) begin
                    check($sformatf("f1_t%0d_hs", t), hs, tbl[i].hs);
                    check($sformatf("f1_t%0d_vs", t), vs, tbl[i].vs);
                    check($sformatf("f1_t%0d_blank", t), blank, tbl[i].blank);
                    check($sformatf("f1_t%0d_rd", t), fif.fifo_read, tbl[i].rd);
                    check($sformatf("f1_t%0d_fs", t), frame_start, tbl[i].fs);
                    check($sformatf("f1_t%0d_rgb", t), rgb, tbl[i].rgb);
                end
            end
        end
        check("f1_hs_low_cycles", c_hs, 5);
        check("f1_vs_low_cycles", c_vs, 7);
        check("f1_blank_cycles", c_bl, 8);
        check("f1_read_cycles", c_rd, 8);

        // Frame 2: FIFO empty for the first three active pixels
        for (int t = 1; t <= 35; t++) begin
            tick();
            if (t >= 24 && t <= 26) begin
                check($sformatf("uf_t%0d_blank", t), blank, 1);
                check($sformatf("uf_t%0d_rgb", t), rgb, 0);
                check($sformatf("uf_t%0d_rd", t), fif.fifo_read, 1);
            end
            if (t == 26) check("uf_cnt", underflow_cnt, 3);
            if (t == 27) check("uf_rgb_resume", rgb, 9);
            if (t == 34) check("uf_rgb_last", rgb, 13);
            if (t == 35) begin
                check("uf_period_fs", frame_start, 1);
                check("uf_cnt_end", underflow_cnt, 3);
            end
            force_empty = (t >= 23 && t <= 25);
        end

        // Frame 3: enable dropped at cycle 5, frame must still complete
        c_rd = 0;
        for (int t = 1; t <= 35; t++) begin
            tick();
            if (t <= 33 && fif.fifo_read) c_rd++;
            if (t == 4) enable = 1'b0;
            if (t == 33) check("stop_busy_wrap", busy, 1);
            if (t == 34) begin
                check("stop_busy", busy, 0);
                check("stop_last_blank", blank, 1);
                check("stop_last_rgb", rgb, 21);
            end
            if (t == 35) begin
                check("stop_blank", blank, 0);
                check("stop_fs", frame_start, 0);
                check("stop_hs", hs, 1);
                check("stop_vs", vs, 1);
                check("stop_rd", fif.fifo_read, 0);
                check("stop_rgb", rgb, 0);
            end
        end
        check("stop_reads", c_rd, 8);
        repeat (3) tick();
        check("stop_idle_busy", busy, 0);
        check("stop_idle_fs", frame_start, 0);

        // Saturation: permanently empty for about 40 frames
        force_empty = 1'b1;
        enable      = 1'b1;
        nz = 0;
        repeat (1410) begin
            tick();
            if (rgb != 24'd0) nz++;
        end
        check("sat_cnt", underflow_cnt, 255);
        check("sat_rgb_nonzero", nz, 0);
        check("sat_busy", busy, 1);

        // Asynchronous reset in the middle of the active area
        force_empty = 1'b0;
        n = 0;
        found = 0;
        while (!found && n < 40) begin
            tick();
            n++;
            if (frame_start) found = 1;
        end
        check("ar_found_fs", found, 1);
        repeat (25) tick();
        check("ar_pre_blank", blank, 1);
        check("ar_pre_rgb_nz", (rgb != 24'd0), 1);
        #2;
        pixel_rst = 1'b1;
        #1;
        check_reset_values("ar");
        tick();
        tick();
        pixel_rst = 1'b0;
        n = 0;
        found = 0;
        while (!found && n < 10) begin
            tick();
            n++;
            if (n == 1) check("ar_wait_fill_busy", busy, 1);
            if (frame_start) found = 1;
        end
        check("ar_restart_latency", n, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
